// File: rtl/mpeg_stream_fifo_mw.sv
// Mixed-width stream FIFO: byte writes, RATIO-byte word reads, with pad-to-word and flush.
// Word fetch goes through a registered RAM read that doubles as the output holding register.
module mpeg_stream_fifo_mw #(
    parameter int         RATIO       = 4,
    parameter int         DEPTH_WORDS = 8192,
    parameter int         BIG_ENDIAN  = 0,
    parameter logic [7:0] PAD_BYTE    = 8'h00
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    flush,
    input  logic [7:0]                              in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    pad,
    output logic [8*RATIO-1:0]                      out_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [$clog2(DEPTH_WORDS*RATIO):0]      level_bytes,
    output logic                                    empty,
    output logic                                    overflow
);
    localparam int CAP = DEPTH_WORDS * RATIO;
    localparam int LB  = $clog2(RATIO);
    localparam int AW  = $clog2(DEPTH_WORDS);
    localparam int PW  = $clog2(CAP) + 1;
    localparam int WW  = AW + 1;

    logic [PW-1:0]            wr_ptr;
    logic [WW-1:0]            fetch_ptr, cons_ptr;
    logic [WW-1:0]            words_avail;
    logic [LB-1:0]            partial;
    logic                     clear, full, wr_en, pad_en, fetch, consume;
    logic [RATIO-1:0]         lane_we;
    logic [RATIO-1:0][7:0]    mem [DEPTH_WORDS];

    assign clear       = reset || flush;
    assign partial     = wr_ptr[LB-1:0];
    assign level_bytes = wr_ptr - {cons_ptr, {LB{1'b0}}};
    assign full        = (level_bytes == PW'(CAP));
    assign empty       = (level_bytes == '0);
    assign in_ready    = !full && !pad;
    assign wr_en       = in_valid && in_ready && !clear;
    assign pad_en      = pad && (partial != '0) && !clear;
    // Only words whose last byte is already committed count as fetchable.
    assign words_avail = wr_ptr[PW-1:LB] - fetch_ptr;
    assign fetch       = !clear && (words_avail != '0) && (!out_valid || out_ready);
    assign consume     = out_valid && out_ready;

    for (genvar p = 0; p < RATIO; p++) begin : g_lane
        localparam int L = (BIG_ENDIAN != 0) ? RATIO - 1 - p : p;
        assign lane_we[p] = (wr_en && (partial == LB'(L))) || (pad_en && (LB'(L) >= partial));
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < RATIO; p++)
            if (lane_we[p]) mem[wr_ptr[PW-2:LB]][p] <= pad_en ? PAD_BYTE : in_data;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr    <= '0;
            fetch_ptr <= '0;
            cons_ptr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= in_valid && !in_ready;
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            else if (pad_en)
                wr_ptr <= {wr_ptr[PW-1:LB] + WW'(1), {LB{1'b0}}};
            if (consume)
                cons_ptr <= cons_ptr + WW'(1);
            if (fetch) begin
                out_data  <= mem[fetch_ptr[AW-1:0]];
                fetch_ptr <= fetch_ptr + WW'(1);
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mpeg_stream_fifo_mw.sv
// Bench: LE and BE instances share stimulus; a byte-queue model checks every cycle,
// directed literals pin the model on the documented scenarios.
module tb_mpeg_stream_fifo_mw;
    localparam int R   = 4;
    localparam int D   = 16;
    localparam int CAP = R * D;

    logic        clk = 0, reset = 1, flush = 0, pad = 0, in_valid = 0, out_ready = 0;
    logic [7:0]  in_data = 0;
    logic        rdy_le, rdy_be, ov_le, ov_be, emp_le, emp_be, ovf_le, ovf_be;
    logic [31:0] od_le, od_be;
    logic [6:0]  lvl_le, lvl_be;

    mpeg_stream_fifo_mw #(.RATIO(R), .DEPTH_WORDS(D), .BIG_ENDIAN(0), .PAD_BYTE(8'h00)) u_le (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_le), .pad(pad), .out_data(od_le), .out_valid(ov_le), .out_ready(out_ready),
        .level_bytes(lvl_le), .empty(emp_le), .overflow(ovf_le));
    mpeg_stream_fifo_mw #(.RATIO(R), .DEPTH_WORDS(D), .BIG_ENDIAN(1), .PAD_BYTE(8'h00)) u_be (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_be), .pad(pad), .out_data(od_be), .out_valid(ov_be), .out_ready(out_ready),
        .level_bytes(lvl_be), .empty(emp_be), .overflow(ovf_be));

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    bit run = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    // Model: bytes committed but not yet fetched, plus the word held at the output.
    logic [7:0]  wq[$];
    logic [31:0] m_le = 0, m_be = 0;
    bit          m_ov = 0, m_ovf = 0;

    always @(posedge clk) begin
        int lvl;
        bit acc;
        if (reset || flush) begin
            wq.delete(); m_ov = 0; m_le = 0; m_be = 0; m_ovf = 0;
        end else begin
            lvl = wq.size() + (m_ov ? R : 0);
            acc = in_valid && lvl < CAP && !pad;
            m_ovf = in_valid && !acc;
            if (wq.size() >= R && (!m_ov || out_ready)) begin
                for (int i = 0; i < R; i++) begin
                    m_le[8*i +: 8]       = wq[0];
                    m_be[8*(R-1-i) +: 8] = wq[0];
                    void'(wq.pop_front());
                end
                m_ov = 1;
            end else if (m_ov && out_ready) m_ov = 0;
            if (acc) wq.push_back(in_data);
            else if (pad && lvl % R != 0)
                repeat (R - lvl % R) wq.push_back(8'h00);
        end
        #1;
        if (run) begin
            lvl = wq.size() + (m_ov ? R : 0);
            chk("out_valid_le", ov_le, m_ov);
            chk("out_valid_be", ov_be, m_ov);
            chk("out_data_le", od_le, m_le);
            chk("out_data_be", od_be, m_be);
            chk("level_le", lvl_le, lvl);
            chk("level_be", lvl_be, lvl);
            chk("empty", emp_le, lvl == 0);
            chk("overflow", ovf_le, m_ovf);
            chk("in_ready", rdy_le, lvl < CAP && !pad);
        end
    end

    task automatic step(input bit iv, input logic [7:0] d, input bit pd, input bit ordy, input bit fl);
        in_valid = iv; in_data = d; pad = pd; out_ready = ordy; flush = fl;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        run = 1;
        reset = 0;
        chk("rst_level", lvl_le, 0);
        chk("rst_empty", emp_le, 1);
        chk("rst_out_valid", ov_le, 0);
        chk("rst_out_data", od_le, 0);

        // 1/2: four bytes -> one word in both byte orders
        step(1, 8'h11, 0, 0, 0); step(1, 8'h22, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0); step(1, 8'h44, 0, 0, 0);
        chk("t1_not_yet", ov_le, 0);
        step(0, 0, 0, 0, 0);
        chk("t1_valid", ov_le, 1);
        chk("t1_data_le", od_le, 32'h44332211);
        chk("t2_data_be", od_be, 32'h11223344);
        chk("t1_level", lvl_le, 4);
        step(0, 0, 0, 1, 0);
        chk("t2_level", lvl_le, 0);
        chk("t2_empty", emp_le, 1);
        chk("t2_out_valid", ov_le, 0);

        // 3: fill to capacity, overflow attempt, drain across the wrap
        for (int i = 0; i < CAP; i++) step(1, 8'(i * 7 + 3), 0, 0, 0);
        chk("t3_full_level", lvl_le, CAP);
        chk("t3_in_ready", rdy_le, 0);
        step(1, 8'hEE, 0, 0, 0);
        chk("t3_overflow", ovf_le, 1);
        chk("t3_level_held", lvl_le, CAP);
        for (int i = 0; i < D + 3; i++) step(0, 0, 0, 1, 0);
        chk("t3_drained", lvl_le, 0);

        // 4: pad a partial word, then a no-op pad
        step(1, 8'hAA, 0, 0, 0); step(1, 8'hBB, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t4_data_le", od_le, 32'h0000BBAA);
        chk("t4_data_be", od_be, 32'hAABB0000);
        chk("t4_level", lvl_le, 4);
        step(0, 0, 1, 0, 0);
        chk("t4_pad_noop", lvl_le, 4);
        step(0, 0, 0, 1, 0);

        // 5: continuous streaming for 3*D words
        for (int i = 0; i < 3 * D * R; i++) step(1, 8'($urandom), 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        chk("t5_drained", lvl_le, 0);

        // 6: flush with data queued and a simultaneous write
        for (int i = 0; i < 7; i++) step(1, 8'(8'h50 + i), 0, 0, 0);
        chk("t6_pre_valid", ov_le, 1);
        step(1, 8'h99, 0, 0, 1);
        chk("t6_level", lvl_le, 0);
        chk("t6_out_valid", ov_le, 0);
        step(1, 8'h01, 0, 0, 0); step(1, 8'h02, 0, 0, 0);
        step(1, 8'h03, 0, 0, 0); step(1, 8'h04, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t6_fresh_word", od_le, 32'h04030201);

        // random traffic with occasional pad and flush
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 19) == 0,
                 (i / 200) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0,
                 $urandom_range(0, 299) == 0);

        run = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
